wash_tank_model: RTL and testbench

// - Plant model for the washing-machine demo: closes the loop around the wash controller FSM on the FPGA board.
// - Consumes controller outputs water_in, drain, heat_r; produces the sensor inputs full, empty, cold the controller needs.
// - Simulates drum water level and water temperature as saturating counters stepped at prescaled rates.
// - Exposes level/temp for LEDs/7-seg, plus sticky fault flags.

---
 rtl/wash_pkg.sv | 26 ++
 rtl/wash_tank_model_if.sv | 27 ++
 rtl/wash_tank_model_sat_step_counter.sv | 74 +++++++
 rtl/wash_tank_model.sv | 84 ++++++++
 tb/tb_wash_tank_model.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wash_pkg.sv
// Shared constants and types for the washing-machine demo (controller and tank plant model).
package wash_pkg;

    localparam int unsigned VAL_W = 4;

    typedef logic [VAL_W-1:0] level_t;
    typedef logic [VAL_W-1:0] temp_t;
    typedef logic [VAL_W-1:0] sat_val_t;

    // Real-time rates at a 50 MHz clock
    localparam int unsigned FILL_TICKS  = 200000000 / 8;
    localparam int unsigned DRAIN_TICKS = 100000000 / 8;
    localparam int unsigned HEAT_TICKS  = 50000000;
    localparam int unsigned COOL_TICKS  = 250000000;

    localparam int unsigned LEVEL_MAX = 10;
    localparam int unsigned TEMP_MAX  = 12;
    localparam int unsigned COLD_THR  = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DN   = 2'd2
    } step_mode_e;

endpackage

// File: rtl/wash_tank_model_if.sv
// Controller <-> tank plant signal bundle: actuators one way, sensors and status the other.
interface wash_tank_model_if;
    import wash_pkg::*;

    logic   water_in;
    logic   drain;
    logic   heat_r;
    logic   err_clr;
    logic   full;
    logic   empty;
    logic   cold;
    level_t level;
    temp_t  temp;
    logic   err_conflict;
    logic   err_dryheat;

    modport master (
        output water_in, drain, heat_r, err_clr,
        input  full, empty, cold, level, temp, err_conflict, err_dryheat
    );

    modport slave (
        input  water_in, drain, heat_r, err_clr,
        output full, empty, cold, level, temp, err_conflict, err_dryheat
    );

endinterface

// File: rtl/wash_tank_model_sat_step_counter.sv
// Saturating up/down value stepped once per prescaled interval; the interval restarts on any mode change.
module sat_step_counter
    import wash_pkg::*;
#(
    parameter int unsigned UP_TICKS = 1,
    parameter int unsigned DN_TICKS = 1,
    parameter int unsigned MAX      = 15
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     up,
    input  logic     dn,
    input  logic     load0,
    output sat_val_t value,
    output logic     inc_c
);

    localparam logic [31:0] UP_M1 = 32'(UP_TICKS - 1);
    localparam logic [31:0] DN_M1 = 32'(DN_TICKS - 1);
    localparam sat_val_t    MAX_V = VAL_W'(MAX);

    step_mode_e  mode;
    step_mode_e  prev_mode;
    logic [31:0] presc;
    logic [31:0] cnt_eff;
    logic        wrap;

    // A mode change makes the current cycle the first of a fresh interval
    always_comb begin
        mode    = MODE_HOLD;
        cnt_eff = presc;
        wrap    = 1'b0;
        if (up && !dn) begin
            mode = MODE_UP;
        end else if (dn && !up) begin
            mode = MODE_DN;
        end
        if (mode != prev_mode) begin
            cnt_eff = '0;
        end
        if (mode == MODE_UP) begin
            wrap = (cnt_eff == UP_M1);
        end else if (mode == MODE_DN) begin
            wrap = (cnt_eff == DN_M1);
        end
        inc_c = wrap && (mode == MODE_UP) && (value < MAX_V);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value     <= '0;
            presc     <= '0;
            prev_mode <= MODE_HOLD;
        end else begin
            prev_mode <= mode;
            if (load0) begin
                value <= '0;
                presc <= '0;
            end else if (mode == MODE_HOLD) begin
                presc <= '0;
            end else if (wrap) begin
                presc <= '0;
                if (mode == MODE_UP && value < MAX_V) begin
                    value <= value + VAL_W'(1);
                end else if (mode == MODE_DN && value != '0) begin
                    value <= value - VAL_W'(1);
                end
            end else begin
                presc <= cnt_eff + 32'd1;
            end
        end
    end

endmodule

// File: rtl/wash_tank_model.sv
// Tank plant model: water level and temperature closed around the wash controller, with sticky fault flags.
module wash_tank_model
    import wash_pkg::*;
#(
    parameter int unsigned FILL_TICKS  = wash_pkg::FILL_TICKS,
    parameter int unsigned DRAIN_TICKS = wash_pkg::DRAIN_TICKS,
    parameter int unsigned HEAT_TICKS  = wash_pkg::HEAT_TICKS,
    parameter int unsigned COOL_TICKS  = wash_pkg::COOL_TICKS,
    parameter int unsigned LEVEL_MAX   = wash_pkg::LEVEL_MAX,
    parameter int unsigned TEMP_MAX    = wash_pkg::TEMP_MAX,
    parameter int unsigned COLD_THR    = wash_pkg::COLD_THR
) (
    input logic               clk,
    input logic               reset,
    wash_tank_model_if.slave  bus
);

    level_t level_q;
    temp_t  temp_q;
    logic   empty_c;
    logic   fill;
    logic   drn;
    logic   heat;
    logic   fresh;
    logic   level_inc_c;
    logic   temp_inc_unused;
    logic   err_conflict_q;
    logic   err_dryheat_q;

    assign empty_c = (level_q == '0);
    assign fill    = bus.water_in & ~bus.drain;
    assign drn     = bus.drain & ~bus.water_in;
    assign heat    = bus.heat_r & ~empty_c;
    // Level stepping 0->1 means fresh cold water: temperature restarts from zero
    assign fresh   = level_inc_c & empty_c;

    sat_step_counter #(
        .UP_TICKS (FILL_TICKS),
        .DN_TICKS (DRAIN_TICKS),
        .MAX      (LEVEL_MAX)
    ) u_level (
        .clk   (clk),
        .reset (reset),
        .up    (fill),
        .dn    (drn),
        .load0 (1'b0),
        .value (level_q),
        .inc_c (level_inc_c)
    );

    sat_step_counter #(
        .UP_TICKS (HEAT_TICKS),
        .DN_TICKS (COOL_TICKS),
        .MAX      (TEMP_MAX)
    ) u_temp (
        .clk   (clk),
        .reset (reset),
        .up    (heat),
        .dn    (~heat),
        .load0 (fresh),
        .value (temp_q),
        .inc_c (temp_inc_unused)
    );

    // Sticky faults; a present fault wins over a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_conflict_q <= 1'b0;
            err_dryheat_q  <= 1'b0;
        end else begin
            err_conflict_q <= (bus.water_in & bus.drain) | (err_conflict_q & ~bus.err_clr);
            err_dryheat_q  <= (bus.heat_r & empty_c) | (err_dryheat_q & ~bus.err_clr);
        end
    end

    assign bus.level        = level_q;
    assign bus.temp         = temp_q;
    assign bus.full         = (level_q == VAL_W'(LEVEL_MAX));
    assign bus.empty        = empty_c;
    assign bus.cold         = (temp_q < VAL_W'(COLD_THR));
    assign bus.err_conflict = err_conflict_q;
    assign bus.err_dryheat  = err_dryheat_q;

endmodule

// File: tb/tb_wash_tank_model.sv
// Randomized and directed bench for wash_tank_model against an elapsed-time reference model.
module tb_wash_tank_model;

    localparam int unsigned FILL = 4;
    localparam int unsigned DRN  = 2;
    localparam int unsigned HEAT = 3;
    localparam int unsigned COOL = 5;
    localparam int unsigned LMAX = 10;
    localparam int unsigned TMAX = 12;
    localparam int unsigned CTHR = 8;

    logic clk;
    logic reset;

    wash_tank_model_if bus ();

    wash_tank_model #(
        .FILL_TICKS  (FILL),
        .DRAIN_TICKS (DRN),
        .HEAT_TICKS  (HEAT),
        .COOL_TICKS  (COOL),
        .LEVEL_MAX   (LMAX),
        .TEMP_MAX    (TMAX),
        .COLD_THR    (CTHR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: values plus cycles elapsed in the current activity
    int m_level, m_temp, m_conf, m_dry;
    int l_act, l_elapsed, t_act, t_elapsed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_temp = 0; m_conf = 0; m_dry = 0;
        l_act = 0; l_elapsed = 0; t_act = 0; t_elapsed = 0;
    endtask

    task automatic model_clock(input int wi, input int dr, input int ht, input int clr);
        int la, ta, lvl_next, tmp_next;
        bit was_empty, fresh;
        was_empty = (m_level == 0);
        la = (wi && !dr) ? 1 : (dr && !wi) ? 2 : 0;
        ta = (ht && !was_empty) ? 1 : 2;
        lvl_next = m_level;
        tmp_next = m_temp;
        fresh = 0;
        if (la != l_act) l_elapsed = 0;
        l_act = la;
        if (la == 0) begin
            l_elapsed = 0;
        end else begin
            l_elapsed++;
            if (la == 1 && l_elapsed % FILL == 0 && m_level < LMAX) begin
                lvl_next = m_level + 1;
                fresh = was_empty;
            end
            if (la == 2 && l_elapsed % DRN == 0 && m_level > 0) lvl_next = m_level - 1;
        end
        if (ta != t_act) t_elapsed = 0;
        t_act = ta;
        t_elapsed++;
        if (ta == 1 && t_elapsed % HEAT == 0 && m_temp < TMAX) tmp_next = m_temp + 1;
        if (ta == 2 && t_elapsed % COOL == 0 && m_temp > 0) tmp_next = m_temp - 1;
        if (fresh) begin
            tmp_next = 0;
            t_elapsed = 0;
        end
        m_conf = (wi && dr) || (m_conf && !clr);
        m_dry  = (ht && was_empty) || (m_dry && !clr);
        m_level = lvl_next;
        m_temp = tmp_next;
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".level"}, 32'(bus.level), 32'(m_level));
        check({ph, ".temp"}, 32'(bus.temp), 32'(m_temp));
        check({ph, ".full"}, 32'(bus.full), 32'(m_level == LMAX));
        check({ph, ".empty"}, 32'(bus.empty), 32'(m_level == 0));
        check({ph, ".cold"}, 32'(bus.cold), 32'(m_temp < CTHR));
        check({ph, ".err_conflict"}, 32'(bus.err_conflict), 32'(m_conf));
        check({ph, ".err_dryheat"}, 32'(bus.err_dryheat), 32'(m_dry));
    endtask

    task automatic cyc(input string ph, input int wi, input int dr, input int ht, input int clr);
        bus.water_in = 1'(wi);
        bus.drain    = 1'(dr);
        bus.heat_r   = 1'(ht);
        bus.err_clr  = 1'(clr);
        @(posedge clk);
        #1;
        model_clock(wi, dr, ht, clr);
        compare_all(ph);
    endtask

    initial begin
        int kind, len, wi, dr, ht;
        reset = 1'b1;
        bus.water_in = 1'b0; bus.drain = 1'b0; bus.heat_r = 1'b0; bus.err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;

        // Fill from empty: one level per FILL cycles, full at cycle 40, then saturate
        for (int i = 1; i <= 46; i++) begin
            cyc("fill", 1, 0, 0, 0);
            check("fill.level_rate", 32'(bus.level), 32'((i / 4 > 10) ? 10 : i / 4));
        end
        check("fill.full_held", 32'(bus.full), 32'd1);

        // Drain from full: one level per DRN cycles, empty at cycle 20
        for (int i = 1; i <= 20; i++) begin
            cyc("drain", 0, 1, 0, 0);
            check("drain.level_rate", 32'(bus.level), 32'(10 - i / 2));
        end
        check("drain.empty_at_20", 32'(bus.empty), 32'd1);

        // Dry heating: no temperature rise, sticky flag
        repeat (6) cyc("dryheat", 0, 0, 1, 0);
        check("dryheat.flag", 32'(bus.err_dryheat), 32'd1);
        cyc("dryclr", 0, 0, 0, 1);
        check("dryheat.cleared", 32'(bus.err_dryheat), 32'd0);

        // Fill with an interruption mid-interval, up to level 5
        repeat (2) cyc("refill", 1, 0, 0, 0);
        cyc("refill_gap", 0, 0, 0, 0);
        repeat (3) cyc("refill", 1, 0, 0, 0);
        check("refill.restart_no_step", 32'(bus.level), 32'd0);
        cyc("refill", 1, 0, 0, 0);
        check("refill.restart_step", 32'(bus.level), 32'd1);
        repeat (16) cyc("refill", 1, 0, 0, 0);
        check("refill.level5", 32'(bus.level), 32'd5);

        // Heating at level 5: temp 8 after 24 cycles, then cooling
        for (int i = 1; i <= 24; i++) cyc("heat", 0, 0, 1, 0);
        check("heat.temp8", 32'(bus.temp), 32'd8);
        check("heat.not_cold", 32'(bus.cold), 32'd0);
        repeat (3) cyc("heat9", 0, 0, 1, 0);
        repeat (5) cyc("cool", 0, 0, 0, 0);
        check("cool.temp8", 32'(bus.temp), 32'd8);
        repeat (5) cyc("cool", 0, 0, 0, 0);
        check("cool.cold", 32'(bus.cold), 32'd1);

        // Drain to zero, then refill: temp reloads 0 on the 0->1 step
        repeat (10) cyc("drain0", 0, 1, 0, 0);
        repeat (4) cyc("fresh", 1, 0, 1, 0);
        check("fresh.temp0", 32'(bus.temp), 32'd0);
        repeat (8) cyc("fill3", 1, 0, 0, 0);

        // Conflict at level 3
        cyc("conflict", 1, 1, 0, 0);
        check("conflict.hold", 32'(bus.level), 32'd3);
        cyc("conflict_clr_set", 1, 1, 0, 1);
        check("conflict.set_wins", 32'(bus.err_conflict), 32'd1);
        cyc("conflict_clr", 0, 0, 0, 1);
        check("conflict.cleared", 32'(bus.err_conflict), 32'd0);

        // Asynchronous reset mid-fill at level 5
        repeat (8) cyc("fill5", 1, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_reset");
        @(posedge clk);
        #1;
        compare_all("async_reset_hold");
        reset = 1'b0;

        // Randomized activity runs
        repeat (150) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 30));
            wi = (kind <= 3) ? 1 : (kind == 9 ? 1 : 0);
            dr = (kind >= 4 && kind <= 6) ? 1 : (kind == 9 ? 1 : 0);
            ht = int'($urandom_range(0, 1));
            if (kind == 9) len = 1;
            for (int i = 0; i < len; i++) begin
                cyc("rand", wi, dr, ht, ($urandom_range(0, 15) == 0) ? 1 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog in case the stimulus stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
